// File: rtl/serial_shift_unit_if.sv
// Handshake and data bundle between the control FSM (master) and the serial shifter (slave).
interface serial_shift_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   data_in;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH-1:0]   result;
   logic               busy;
   logic               done;

   modport master (
      output start, op, data_in, shamt,
      input  result, busy, done
   );

   modport slave (
      input  start, op, data_in, shamt,
      output result, busy, done
   );
endinterface

// File: rtl/serial_shift_unit.sv
// Iterative one-bit-per-clock shifter (SRL, SRA, SLL, ROR) with start/busy/done handshake.
module serial_shift_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
   input logic               clk,
   input logic               rst,
   serial_shift_unit_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic [SHAMT_W-1:0] count_q, count_d;
   logic [1:0]         op_q, op_d;
   logic [WIDTH-1:0]   shifted;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (bus.start) state_d = (bus.shamt != '0) ? StShift : StDone;
         StShift: if (count_q == SHAMT_W'(1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.busy   = (state_q != StIdle);
      bus.done   = (state_q == StDone);
      bus.result = result_q;
   end

   // One-position shift of the working register under the latched op.
   always_comb begin
      shifted = result_q;
      unique case (op_q)
         2'b00: shifted = {1'b0, result_q[WIDTH-1:1]};
         2'b01: shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
         2'b10: shifted = {result_q[WIDTH-2:0], 1'b0};
         2'b11: shifted = {result_q[0], result_q[WIDTH-1:1]};
      endcase
   end

   always_comb begin
      result_d = result_q;
      count_d  = count_q;
      op_d     = op_q;
      if (state_q == StIdle && bus.start) begin
         result_d = bus.data_in;
         count_d  = bus.shamt;
         op_d     = bus.op;
      end else if (state_q == StShift) begin
         result_d = shifted;
         count_d  = count_q - SHAMT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_q <= '0;
         count_q  <= '0;
         op_q     <= '0;
      end else begin
         result_q <= result_d;
         count_q  <= count_d;
         op_q     <= op_d;
      end
   end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: directed cases plus random ops against an arithmetic model.
module tb_serial_shift_unit;
   localparam int unsigned W  = 32;
   localparam int unsigned SW = 5;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   serial_shift_unit_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();

   serial_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Reference: whole shift in one step; ROR by amount modulo W.
   function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] d,
                                          input int s);
      int r;
      case (op)
         2'd0: return d >> s;
         2'd1: return W'($signed(d) >>> s);
         2'd2: return d << s;
         default: begin
            r = s % W;
            if (r == 0) return d;
            return (d >> r) | (d << (W - r));
         end
      endcase
   endfunction

   task automatic wait_done(output int k, output int busy_cnt);
      k = -1;
      busy_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] d,
                         input int s);
      int k, bc;
      logic [W-1:0] exp;
      exp = model(op, d, s);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.data_in = d;
      bus.shamt   = SW'(s);
      @(posedge clk);
      #1;
      // Scramble operands after capture; only latched copies may matter.
      bus.start   = 1'b0;
      bus.op      = 2'($urandom);
      bus.data_in = $urandom;
      bus.shamt   = SW'($urandom);
      wait_done(k, bc);
      check({tag, "_latency"}, k, s);
      check({tag, "_busy_cycles"}, bc, s + 1);
      check({tag, "_result"}, bus.result, exp);
      @(negedge clk);
      check({tag, "_idle_busy"}, bus.busy, 1'b0);
      check({tag, "_idle_done"}, bus.done, 1'b0);
      check({tag, "_hold"}, bus.result, exp);
   endtask

   initial begin
      int k, bc;
      logic [1:0] rop;
      logic [W-1:0] rd;
      int rs;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.op = 2'd0;
      bus.data_in = '0;
      bus.shamt = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_result", bus.result, '0);
      rst = 1'b1;

      run_op("srl4", 2'd0, 32'hF000_0000, 4);
      run_op("sra31", 2'd1, 32'h8000_0000, 31);
      run_op("srl31", 2'd0, 32'h8000_0000, 31);
      run_op("ror31", 2'd3, 32'h8000_0000, 31);
      run_op("sll2", 2'd2, 32'h01C7_1C71, 2);
      run_op("zero", 2'd1, 32'hDEAD_BEEF, 0);

      // Start held high across SHIFT and DONE with changing operands.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'd0;
      bus.data_in = 32'hA5A5_A5A5;
      bus.shamt = SW'(6);
      @(posedge clk);
      #1;
      bus.data_in = 32'h1234_5678;
      bus.shamt = SW'(3);
      wait_done(k, bc);
      check("busy_start_latency", k, 6);
      check("busy_start_result", bus.result, 32'hA5A5_A5A5 >> 6);
      @(negedge clk);
      check("done_start_ignored", bus.busy, 1'b0);
      check("done_start_hold", bus.result, 32'hA5A5_A5A5 >> 6);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(k, bc);
      check("held_start_latency", k, 3);
      check("held_start_result", bus.result, 32'h1234_5678 >> 3);

      // Reset two cycles into an SRA by 10.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 2'd1;
      bus.data_in = 32'h8000_0000;
      bus.shamt = SW'(10);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_busy", bus.busy, 1'b0);
      check("midrst_done", bus.done, 1'b0);
      check("midrst_result", bus.result, '0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("midrst_no_done", bus.done, 1'b0);
      end
      rst = 1'b1;
      run_op("post_rst_srl8", 2'd0, 32'h0000_0100, 8);

      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom);
         rd  = $urandom;
         rs  = int'($urandom_range(0, 31));
         run_op($sformatf("rand%0d", i), rop, rd, rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end expected end");
      $fatal(1);
   end
endmodule

// File: doc/serial_shift_unit.md
# serial_shift_unit

Iterative multi-cycle shifter for the ALU's shift instructions (SLL, SRL, SRA, ROR). It moves one bit position per clock under a start/busy/done handshake. It complements the fixed combinational left-by-2 address shifter by providing variable-amount, right-capable shifting. It sits beside the ALU and is sequenced by the control FSM, which stalls the PC while `busy` is high.

## Interface
- `WIDTH`, default 32: data path width.
- `SHAMT_W`, default 5: shift-amount width; must satisfy 2^SHAMT_W >= WIDTH.
- `clk`, in, 1: single clock; everything is sampled on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a shift; honoured only in IDLE.
- `op`, in, 2: operation. 00 = SRL, 01 = SRA, 10 = SLL, 11 = ROR.
- `data_in`, in, WIDTH: operand, captured on the accepting edge.
- `shamt`, in, SHAMT_W: shift amount, captured on the accepting edge.
- `result`, out, WIDTH: shift register contents; final value is valid when `done` is high.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: high for exactly one cycle (the DONE state).

## Operation
- **States:** IDLE, SHIFT, DONE. The state register, `result` register and count register (SHAMT_W bits) are all clocked.
- **IDLE:**
  - If `start` is 1 on an edge: `result` <= `data_in`, op is latched, count <= `shamt`.
  - Next state is SHIFT if `shamt` != 0, otherwise DONE.
  - If `start` is 0, all registers hold.
- **SHIFT, each edge:** shift `result` one bit, count <= count - 1. When count == 1 on that edge, next state is DONE; otherwise stay in SHIFT.
- **Per-bit rules:**
  - SRL: `result` <= {0, result[W-1:1]}.
  - SRA: `result` <= {result[W-1], result[W-1:1]}.
  - SLL: `result` <= {result[W-2:0], 0}.
  - ROR: `result` <= {result[0], result[W-1:1]}.
- **DONE:** `done` = 1, `result` holds. Next state is always IDLE.
- **Start handling:** `start` is ignored in SHIFT and DONE; there is no queuing. A new `start` can be accepted on the first edge back in IDLE.
- **Operand capture:** `op`, `data_in` and `shamt` may change freely after the accepting edge; only latched copies are used.
- **`result` between operations:** holds the last final value until the next accepted `start`. During SHIFT it shows intermediate values, which consumers must ignore.
- **Large shift amounts:** `shamt` >= WIDTH (possible only if 2^SHAMT_W > WIDTH) shifts the full `shamt` count.
  - SRL and SLL give 0.
  - SRA gives the sign fill.
  - ROR gives rotation modulo WIDTH.
- **Outputs:** `busy` and `done` are decoded from the state register only, so they are glitch-free registered decodes.

## Timing
- **Reset values** (asserted at any time, including mid-shift): state = IDLE, `result` = 0, count = 0, `busy` = 0, `done` = 0. An in-flight operation is aborted with no `done` pulse.
- **Deassertion:** the first edge with `rst` high may accept a `start`.
- **Latency:** for a start accepted on edge E0, `done` is high during the cycle after edge E0 + `shamt`.
  - Example: `shamt` = 0 gives `done` right after E0.
  - Example: `shamt` = 31 gives `done` after E0 + 31.
- **Busy window:** `busy` rises after E0 and falls after E0 + `shamt` + 1, which is the edge that leaves DONE.
- **Throughput:** one operation per `shamt` + 2 cycles when `start` is held high continuously.

## Test plan
- **SRL:** `data_in` = 0xF0000000, `shamt` = 4.
  - `result` = 0x0F000000.
  - `done` is high in the cycle after E0 + 4.
  - `busy` is high for 5 cycles.
- **SRA, SRL, ROR by 31:** `data_in` = 0x80000000, `shamt` = 31.
  - SRA gives 0xFFFFFFFF.
  - SRL gives 0x00000001.
  - ROR gives 0x00000001.
  - `done` occurs after E0 + 31.
- **SLL:** `data_in` = 0x01C71C71, `shamt` = 2.
  - `result` = 0x071C71C4.
- **Zero shift:** `shamt` = 0 with `data_in` = 0xDEADBEEF.
  - `done` is high in the cycle right after E0.
  - `result` = 0xDEADBEEF.
- **Start while busy:** a second `start` arrives with a different `data_in` mid-SHIFT and during DONE.
  - Both are ignored.
  - The first result is unaffected.
  - A `start` held high is accepted on the first IDLE edge.
- **Reset mid-shift:** `rst` = 0 two cycles into an SRA by 10.
  - Immediately: `busy` = 0, `done` = 0, `result` = 0.
  - No `done` pulse appears.
  - After release, a fresh SRL 0x00000100 by 8 gives 0x00000001.
